// File: rtl/dram_cmd_timing_gate_pkg.sv
// Shared types and default DDR4 timing values (CLK cycles) for the command timing gate.
package dram_cmd_timing_gate_pkg;

    typedef enum logic [2:0] {
        CK_ACT = 3'd0,
        CK_RD  = 3'd1,
        CK_WR  = 3'd2,
        CK_PRE = 3'd3,
        CK_REF = 3'd4
    } dram_cmd_kind_t;

    localparam int unsigned DEF_T_RCD   = 12;
    localparam int unsigned DEF_T_RP    = 10;
    localparam int unsigned DEF_T_RAS   = 17;
    localparam int unsigned DEF_T_WR    = 12;
    localparam int unsigned DEF_T_CWD   = 12;
    localparam int unsigned DEF_T_BURST = 2;
    localparam int unsigned DEF_T_WTR   = 12;
    localparam int unsigned DEF_T_CCD_S = 4;
    localparam int unsigned DEF_T_CCD_L = 5;
    localparam int unsigned DEF_T_RRD_S = 4;
    localparam int unsigned DEF_T_RRD_L = 4;
    localparam int unsigned DEF_T_FAW   = 25;
    localparam int unsigned DEF_T_RFC   = 128;

    // A constraint of t cycles is held off by a timer loaded with t-1.
    function automatic int unsigned timer_load(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Saturating down-counter: a load raises the count to max(current, load_val).
module dram_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        if (load) begin
            cnt_d = (load_val > cnt_q) ? load_val : cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dram_cmd_timing_gate.sv
// DDR4 command timing gate: holds each request until every relevant timer is clear, tracks
// open banks/rows per (rank, bank group, bank) and drops state-illegal commands with cmd_err.
module dram_cmd_timing_gate
    import dram_cmd_timing_gate_pkg::*;
#(
    parameter int unsigned NUM_RANKS = 1,
    parameter int unsigned BG_BITS   = 2,
    parameter int unsigned BA_BITS   = 2,
    parameter int unsigned ROW_BITS  = 18,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned T_RCD     = DEF_T_RCD,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_RAS     = DEF_T_RAS,
    parameter int unsigned T_WR      = DEF_T_WR,
    parameter int unsigned T_CWD     = DEF_T_CWD,
    parameter int unsigned T_BURST   = DEF_T_BURST,
    parameter int unsigned T_WTR     = DEF_T_WTR,
    parameter int unsigned T_CCD_S   = DEF_T_CCD_S,
    parameter int unsigned T_CCD_L   = DEF_T_CCD_L,
    parameter int unsigned T_RRD_S   = DEF_T_RRD_S,
    parameter int unsigned T_RRD_L   = DEF_T_RRD_L,
    parameter int unsigned T_FAW     = DEF_T_FAW,
    parameter int unsigned T_RFC     = DEF_T_RFC,
    localparam int unsigned RANK_W    = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
    localparam int unsigned NUM_BANKS = NUM_RANKS * (2 ** (BG_BITS + BA_BITS))
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  dram_cmd_kind_t       req_cmd,
    input  logic [RANK_W-1:0]    req_rank,
    input  logic [BG_BITS-1:0]   req_bg,
    input  logic [BA_BITS-1:0]   req_ba,
    input  logic [ROW_BITS-1:0]  req_row,
    output logic                 issue_valid,
    output dram_cmd_kind_t       issue_cmd,
    output logic [RANK_W-1:0]    issue_rank,
    output logic [BG_BITS-1:0]   issue_bg,
    output logic [BA_BITS-1:0]   issue_ba,
    output logic [ROW_BITS-1:0]  issue_row,
    output logic                 cmd_err,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic [NUM_RANKS-1:0] rank_refreshing
);

    localparam int unsigned BANKS_PER_RANK = 2 ** (BG_BITS + BA_BITS);
    localparam int unsigned NUM_GRP = NUM_RANKS * (2 ** BG_BITS);
    localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int unsigned FAW_W   = $clog2(4 * NUM_RANKS);

    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(timer_load(T_RCD));
    localparam logic [CNT_W-1:0] LD_RAS   = CNT_W'(timer_load(T_RAS));
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(timer_load(T_RP));
    localparam logic [CNT_W-1:0] LD_WRP   = CNT_W'(timer_load(T_CWD + T_BURST + T_WR));
    localparam logic [CNT_W-1:0] LD_WTR   = CNT_W'(timer_load(T_CWD + T_BURST + T_WTR));
    localparam logic [CNT_W-1:0] LD_CCD_S = CNT_W'(timer_load(T_CCD_S));
    localparam logic [CNT_W-1:0] LD_CCD_L = CNT_W'(timer_load(T_CCD_L));
    localparam logic [CNT_W-1:0] LD_RRD_S = CNT_W'(timer_load(T_RRD_S));
    localparam logic [CNT_W-1:0] LD_RRD_L = CNT_W'(timer_load(T_RRD_L));
    localparam logic [CNT_W-1:0] LD_FAW   = CNT_W'(timer_load(T_FAW));
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(timer_load(T_RFC));

    logic [NUM_BANKS-1:0] rcd_z, ras_z, rp_z, wrp_z;
    logic [NUM_RANKS-1:0] rrd_s_z, ccd_s_z, wtr_z, rfc_z;
    logic [NUM_RANKS-1:0] rank_rp_clear, rank_any_open;
    logic [NUM_GRP-1:0]   rrd_l_z, ccd_l_z;
    logic [4*NUM_RANKS-1:0] faw_z;

    logic [NUM_BANKS-1:0] bank_open_q;
    logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];
    logic [1:0]           faw_ptr_q  [NUM_RANKS];

    logic                 issue_valid_q, cmd_err_q;
    dram_cmd_kind_t       issue_cmd_q;
    logic [RANK_W-1:0]    issue_rank_q;
    logic [BG_BITS-1:0]   issue_bg_q;
    logic [BA_BITS-1:0]   issue_ba_q;
    logic [ROW_BITS-1:0]  issue_row_q;

    logic [BANK_W-1:0] bidx;
    logic [GRP_W-1:0]  gidx;
    logic [FAW_W-1:0]  fidx;
    logic timing_ok, state_ok, accept, commit;
    logic is_act, is_rd, is_wr, is_pre, is_ref;

    assign bidx = BANK_W'({req_rank, req_bg, req_ba});
    assign gidx = GRP_W'({req_rank, req_bg});
    assign fidx = FAW_W'({req_rank, faw_ptr_q[req_rank]});

    assign is_act = (req_cmd == CK_ACT);
    assign is_rd  = (req_cmd == CK_RD);
    assign is_wr  = (req_cmd == CK_WR);
    assign is_pre = (req_cmd == CK_PRE);
    assign is_ref = (req_cmd == CK_REF);

    always_comb begin
        timing_ok = 1'b1;
        state_ok  = 1'b0;
        case (req_cmd)
            CK_ACT: begin
                timing_ok = rp_z[bidx] && rrd_s_z[req_rank] && rrd_l_z[gidx] && faw_z[fidx];
                state_ok  = !bank_open_q[bidx];
            end
            CK_RD: begin
                timing_ok = rcd_z[bidx] && ccd_s_z[req_rank] && ccd_l_z[gidx] && wtr_z[req_rank];
                state_ok  = bank_open_q[bidx];
            end
            CK_WR: begin
                timing_ok = rcd_z[bidx] && ccd_s_z[req_rank] && ccd_l_z[gidx];
                state_ok  = bank_open_q[bidx];
            end
            CK_PRE: begin
                timing_ok = ras_z[bidx] && wrp_z[bidx];
                state_ok  = bank_open_q[bidx];
            end
            CK_REF: begin
                timing_ok = rank_rp_clear[req_rank];
                state_ok  = !rank_any_open[req_rank];
            end
            default: begin
                timing_ok = 1'b1;
                state_ok  = 1'b0;
            end
        endcase
    end

    assign req_ready = !RST && rfc_z[req_rank] && timing_ok;
    assign accept    = req_valid && req_ready;
    // Only state-legal commands touch timers or bank state.
    assign commit    = accept && state_ok;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic hit;
        assign hit = commit && (bidx == BANK_W'(b));
        dram_timer #(.CNT_W(CNT_W)) u_rcd (.CLK(CLK), .RST(RST), .load(hit && is_act),
                                           .load_val(LD_RCD), .zero(rcd_z[b]));
        dram_timer #(.CNT_W(CNT_W)) u_ras (.CLK(CLK), .RST(RST), .load(hit && is_act),
                                           .load_val(LD_RAS), .zero(ras_z[b]));
        dram_timer #(.CNT_W(CNT_W)) u_rp  (.CLK(CLK), .RST(RST), .load(hit && is_pre),
                                           .load_val(LD_RP), .zero(rp_z[b]));
        dram_timer #(.CNT_W(CNT_W)) u_wrp (.CLK(CLK), .RST(RST), .load(hit && is_wr),
                                           .load_val(LD_WRP), .zero(wrp_z[b]));
    end

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        logic hit;
        assign hit = commit && (req_rank == RANK_W'(r));
        assign rank_rp_clear[r] = &rp_z[r*BANKS_PER_RANK +: BANKS_PER_RANK];
        assign rank_any_open[r] = |bank_open_q[r*BANKS_PER_RANK +: BANKS_PER_RANK];
        dram_timer #(.CNT_W(CNT_W)) u_rrd_s (.CLK(CLK), .RST(RST), .load(hit && is_act),
                                             .load_val(LD_RRD_S), .zero(rrd_s_z[r]));
        dram_timer #(.CNT_W(CNT_W)) u_ccd_s (.CLK(CLK), .RST(RST), .load(hit && (is_rd || is_wr)),
                                             .load_val(LD_CCD_S), .zero(ccd_s_z[r]));
        dram_timer #(.CNT_W(CNT_W)) u_wtr   (.CLK(CLK), .RST(RST), .load(hit && is_wr),
                                             .load_val(LD_WTR), .zero(wtr_z[r]));
        dram_timer #(.CNT_W(CNT_W)) u_rfc   (.CLK(CLK), .RST(RST), .load(hit && is_ref),
                                             .load_val(LD_RFC), .zero(rfc_z[r]));
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        logic hit;
        assign hit = commit && (gidx == GRP_W'(g));
        dram_timer #(.CNT_W(CNT_W)) u_rrd_l (.CLK(CLK), .RST(RST), .load(hit && is_act),
                                             .load_val(LD_RRD_L), .zero(rrd_l_z[g]));
        dram_timer #(.CNT_W(CNT_W)) u_ccd_l (.CLK(CLK), .RST(RST), .load(hit && (is_rd || is_wr)),
                                             .load_val(LD_CCD_L), .zero(ccd_l_z[g]));
    end

    // Four-slot ring per rank: an ACT claims the slot under the pointer for tFAW.
    for (genvar s = 0; s < 4 * NUM_RANKS; s++) begin : g_faw
        dram_timer #(.CNT_W(CNT_W)) u_faw (.CLK(CLK), .RST(RST),
                                           .load(commit && is_act && (fidx == FAW_W'(s))),
                                           .load_val(LD_FAW), .zero(faw_z[s]));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_valid_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            issue_cmd_q   <= CK_ACT;
            issue_rank_q  <= '0;
            issue_bg_q    <= '0;
            issue_ba_q    <= '0;
            issue_row_q   <= '0;
            bank_open_q   <= '0;
            for (int i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
            for (int i = 0; i < NUM_RANKS; i++) faw_ptr_q[i] <= '0;
        end else begin
            issue_valid_q <= commit;
            cmd_err_q     <= accept && !state_ok;
            if (accept) begin
                issue_cmd_q  <= req_cmd;
                issue_rank_q <= req_rank;
                issue_bg_q   <= req_bg;
                issue_ba_q   <= req_ba;
                issue_row_q  <= (is_rd || is_wr || is_pre) ? open_row_q[bidx] : req_row;
            end
            if (commit) begin
                case (req_cmd)
                    CK_ACT: begin
                        bank_open_q[bidx]   <= 1'b1;
                        open_row_q[bidx]    <= req_row;
                        faw_ptr_q[req_rank] <= faw_ptr_q[req_rank] + 2'd1;
                    end
                    CK_PRE:  bank_open_q[bidx] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign issue_valid     = issue_valid_q;
    assign cmd_err         = cmd_err_q;
    assign issue_cmd       = issue_cmd_q;
    assign issue_rank      = issue_rank_q;
    assign issue_bg        = issue_bg_q;
    assign issue_ba        = issue_ba_q;
    assign issue_row       = issue_row_q;
    assign bank_open       = bank_open_q;
    assign rank_refreshing = ~rfc_z;

endmodule

// File: tb/tb_dram_cmd_timing_gate.sv
// Directed bench for dram_cmd_timing_gate: acceptance cycles checked inline, issue/err pulses
// checked against a scoreboard of expected outputs filled as each request is accepted.
module tb_dram_cmd_timing_gate;
    import dram_cmd_timing_gate_pkg::*;

    typedef struct {
        logic           err;
        dram_cmd_kind_t cmd;
        logic [1:0]     bg;
        logic [1:0]     ba;
        logic [17:0]    row;
        logic           chk_row;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic           req_valid, req_ready;
    dram_cmd_kind_t req_cmd;
    logic [0:0]     req_rank;
    logic [1:0]     req_bg, req_ba;
    logic [17:0]    req_row;
    logic           issue_valid, cmd_err;
    dram_cmd_kind_t issue_cmd;
    logic [0:0]     issue_rank;
    logic [1:0]     issue_bg, issue_ba;
    logic [17:0]    issue_row;
    logic [15:0]    bank_open;
    logic [0:0]     rank_refreshing;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ref_cnt  = 0;
    exp_t        sb[$];
    logic [15:0] exp_open = '0;
    logic [17:0] exp_row [16];

    dram_cmd_timing_gate dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .issue_valid(issue_valid), .issue_cmd(issue_cmd), .issue_rank(issue_rank),
        .issue_bg(issue_bg), .issue_ba(issue_ba), .issue_row(issue_row), .cmd_err(cmd_err),
        .bank_open(bank_open), .rank_refreshing(rank_refreshing)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (rank_refreshing[0] === 1'b1) ref_cnt <= ref_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Hold a request valid until accepted; returns the acceptance cycle.
    task automatic send(input dram_cmd_kind_t cmd, input int bg, input int ba,
                        input logic [17:0] row, output int t_acc);
        bit   done;
        int   b;
        exp_t e;
        b = bg * 4 + ba;
        req_valid = 1'b1; req_cmd = cmd; req_rank = 1'b0;
        req_bg = bg[1:0]; req_ba = ba[1:0]; req_row = row;
        done = 1'b0;
        t_acc = -1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (req_ready === 1'b1) begin
                done = 1'b1;
                t_acc = cyc;
                e.cmd = cmd; e.bg = bg[1:0]; e.ba = ba[1:0];
                case (cmd)
                    CK_ACT:  e.err = exp_open[b];
                    CK_REF:  e.err = |exp_open;
                    default: e.err = !exp_open[b];
                endcase
                e.row = (cmd == CK_ACT || cmd == CK_REF) ? row : exp_row[b];
                e.chk_row = !e.err;
                sb.push_back(e);
                if (!e.err && cmd == CK_ACT) begin exp_open[b] = 1'b1; exp_row[b] = row; end
                if (!e.err && cmd == CK_PRE) exp_open[b] = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (issue_valid === 1'b1 || cmd_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {issue_valid, cmd_err}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("issue_valid", issue_valid, !e.err);
                check("cmd_err", cmd_err, e.err);
                check("issue_cmd", issue_cmd, e.cmd);
                check("issue_bg", issue_bg, e.bg);
                check("issue_ba", issue_ba, e.ba);
                check("issue_rank", issue_rank, 0);
                if (e.chk_row) check("issue_row", issue_row, e.row);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, c;
        int ta[5];
        int bgs[5];
        int bas[5];
        bgs = '{2, 3, 0, 1, 2};
        bas = '{0, 0, 1, 1, 1};
        for (int i = 0; i < 16; i++) exp_row[i] = '0;

        // Reset, with a request already presented.
        RST = 1'b1; req_valid = 1'b1; req_cmd = CK_ACT; req_rank = 1'b0;
        req_bg = '0; req_ba = '0; req_row = '0;
        idle(2);
        @(negedge CLK);
        check("rst_ready", req_ready, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_bank_open", bank_open, 0);
        check("rst_refreshing", rank_refreshing, 0);
        check("rst_issue_row", issue_row, 0);
        @(posedge CLK); #1;
        RST = 1'b0; req_valid = 1'b0;

        // ACT then RD: tRCD.
        send(CK_ACT, 0, 0, 18'h1234, t0);
        send(CK_RD, 0, 0, 18'h0, t1);
        check("trcd_rd_cycle", t1 - t0, 12);
        idle(2);
        check("act_bank_open", bank_open, 16'h0001);

        // tCCD_L then tCCD_S.
        send(CK_ACT, 1, 0, 18'h0055, t0);
        idle(20);
        send(CK_RD, 0, 0, 18'h0, t0);
        send(CK_RD, 0, 0, 18'h0, t1);
        send(CK_RD, 1, 0, 18'h0, t2);
        check("tccd_l_cycle", t1 - t0, 5);
        check("tccd_s_cycle", t2 - t0, 9);

        // Five ACTs: tRRD spacing then tFAW.
        idle(30);
        for (int i = 0; i < 5; i++) send(CK_ACT, bgs[i], bas[i], 18'(18'h100 + i), ta[i]);
        check("faw_act1", ta[1] - ta[0], 4);
        check("faw_act2", ta[2] - ta[0], 8);
        check("faw_act3", ta[3] - ta[0], 12);
        check("faw_act4", ta[4] - ta[0], 25);

        // WR then RD to another bank: tWTR.
        idle(20);
        send(CK_WR, 0, 0, 18'h0, t0);
        send(CK_RD, 1, 0, 18'h0, t1);
        check("twtr_rd_cycle", t1 - t0, 26);

        // State errors: RD to closed bank, REF with open banks.
        send(CK_RD, 3, 3, 18'h0, t0);
        idle(2);
        check("err_rd_bank_open", bank_open, exp_open);
        send(CK_REF, 0, 0, 18'h0, t0);
        idle(2);
        check("err_ref_bank_open", bank_open, exp_open);
        check("err_ref_no_refresh", rank_refreshing, 0);

        // Close every bank, REF, then ACT after tRFC.
        for (int b = 0; b < 16; b++) if (exp_open[b]) send(CK_PRE, b / 4, b % 4, 18'h0, t0);
        check("all_closed", bank_open, 0);
        ref_cnt = 0;
        send(CK_REF, 0, 0, 18'h0, t0);
        send(CK_ACT, 0, 0, 18'h0abc, t1);
        check("trfc_act_cycle", t1 - t0, 128);
        check("refresh_cycles", ref_cnt, 127);

        // Reset during the tRCD stall of a RD.
        req_valid = 1'b1; req_cmd = CK_RD; req_bg = 2'd0; req_ba = 2'd0;
        @(negedge CLK);
        check("stall_ready", req_ready, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(2);
        @(negedge CLK);
        check("mid_rst_bank_open", bank_open, 0);
        check("mid_rst_issue_valid", issue_valid, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_open = '0;
        for (int i = 0; i < 16; i++) exp_row[i] = '0;
        c = cyc;
        send(CK_ACT, 0, 0, 18'h0077, t0);
        check("post_rst_act_cycle", t0, c);

        idle(4);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
